// File: rtl/decoder24_scan_ctrl.sv
// Round-robin scan controller driving the en/a inputs of a 2-4 decoder.
// Visits the outputs selected by a mask, holding each for div+1 cycles with two blank cycles between.
module decoder24_scan_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [3:0]           mask_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 en_o,
    output logic [1:0]           a_o,
    output logic                 busy_o,
    output logic                 wrap_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLANK_B = 2'd1,
        DWELL   = 2'd2,
        BLANK_A = 2'd3
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 en_q;
    logic [1:0]           a_q;
    logic                 busy_q;
    logic                 wrap_q;

    logic [1:0]           lowIdx_d;
    logic [1:0]           nextIdx_d;
    logic [1:0]           cand;
    logic                 found;

    // Search upward from a_q, wrapping around; with a single-bit mask the search lands back on a_q.
    always_comb begin
        lowIdx_d  = 2'd0;
        nextIdx_d = a_q;
        cand      = a_q;
        found     = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (mask_i[k]) begin
                lowIdx_d = 2'(k);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            cand = a_q + 2'(k);
            if (!found && mask_i[cand]) begin
                nextIdx_d = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            a_q     <= 2'b00;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (stop_i) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    en_q <= 1'b0;
                    if (start_i && (mask_i != 4'b0000)) begin
                        a_q     <= lowIdx_d;
                        busy_q  <= 1'b1;
                        state_q <= BLANK_B;
                    end
                end
                BLANK_B: begin
                    cnt_q   <= div_i;
                    en_q    <= 1'b1;
                    state_q <= DWELL;
                end
                DWELL: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        state_q <= BLANK_A;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                BLANK_A: begin
                    if (mask_i == 4'b0000) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        a_q     <= nextIdx_d;
                        wrap_q  <= (nextIdx_d <= a_q);
                        state_q <= BLANK_B;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign en_o   = en_q;
    assign a_o    = a_q;
    assign busy_o = busy_q;
    assign wrap_o = wrap_q;

endmodule

// File: doc/decoder24_scan_ctrl.md
# decoder24_scan_ctrl

- Sequential front end for the 2-4 decoder.
- Drives the decoder's `en` and `a[1:0]` inputs so that the four decoder outputs are activated one at a time, round-robin. A programmable mask selects which outputs are visited, and a programmable count sets how long each one is held.
- Between steps the decoder is disabled for two cycles, so `a` never changes while `en` is high. This keeps the decoder outputs glitch-free.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the dwell counter and the `div` input.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin scanning. Sampled only in IDLE.
- `stop` in 1: abort scanning. Takes effect from any state.
- `mask` in 4: bit i set means decoder output i is visited.
- `div` in DIV_WIDTH: dwell length minus 1, in cycles.
- `en` out 1: decoder enable. Registered.
- `a` out 2: decoder select. Registered.
- `busy` out 1: high whenever the FSM is not in IDLE. Registered.
- `wrap` out 1: one-cycle pulse when the sequence returns to an index less than or equal to the previous one. Registered.

## Operation
- States: IDLE, BLANK_B, DWELL, BLANK_A.
- In every state, `stop` forces IDLE on the next edge. `stop` wins over `start`.
- **IDLE**
  - `en=0`; `a` holds its last value.
  - If `start` is high and `mask != 0`: set `a` to the lowest set bit index of `mask`, go to BLANK_B, `wrap=0`.
  - If `start` is high and `mask == 0`: `start` is ignored.
- **BLANK_B**
  - `en=0`.
  - Next edge: load the dwell counter with `div`, set `en=1`, go to DWELL.
- **DWELL**
  - `en=1`; the counter decrements each cycle.
  - When the counter is 0: set `en=0`, go to BLANK_A. `a` is unchanged.
- **BLANK_A**
  - `en=0`.
  - Compute next = the next set bit of the current `mask` strictly above `a`. If there is none, wrap to the lowest set bit.
  - If `mask == 0`: go to IDLE with `a` held.
  - Otherwise: `a` ← next and go to BLANK_B. `wrap=1` for that cycle if next ≤ old `a`.
  - With a single-bit mask, next equals `a`, so `wrap` fires on every step.
- **Sampling points**
  - `mask` is sampled only on leaving IDLE and at BLANK_A.
  - `div` is sampled only on entering DWELL.
  - Changes made mid-dwell apply at the next step.
- `busy` is 0 in IDLE and 1 in every other state.
- `start` while busy is ignored.

## Timing
- **Reset**
  - Asynchronous reset immediately forces `en=0`, `a=2'b00`, `busy=0`, `wrap=0`, state IDLE, counter 0.
  - Reset takes effect mid-operation with no clock edge required.
- **Start**
  - `start` sampled at edge E0 gives, after E0: `busy=1`, `a`=lowest mask index, `en=0`.
  - After E0+1: `en=1`.
- **Per step**
  - `en` is high for `div`+1 cycles, then low for 2 cycles.
  - `a` changes only at the edge that ends the first low cycle.
  - Step period is `div`+3 cycles.
- **wrap**
  - Asserted for exactly the cycle in which `a` first shows the wrapped index.
  - Coincident with BLANK_B, while `en=0`.
- **stop**
  - `stop` at edge S gives, after S: `en=0`, `busy=0`, `wrap=0`, `a` held.
- **Invariant:** `en` and `a` never change on the same edge. Any change of `a` occurs while `en=0` before and after.
- **Counter width:** `div` uses its full range (0 to 2^DIV_WIDTH−1) with no overflow. A counter value of 0 terminates the dwell.

## Test plan
- **Reset:** assert `rst` asynchronously mid-DWELL with `div`=5 → `en`, `busy` and `wrap` go 0 and `a`=00 before the next `clk` edge. After release, the FSM stays idle until `start`.
- **Full scan:** `mask`=1111, `div`=2, 1-cycle `start` pulse.
  - `a` sequence is 0,1,2,3,0,…
  - Each step: `en` high 3 cycles, low 2 cycles; 5-cycle period.
  - `wrap` pulses once per 20 cycles, on 3→0.
- **Sparse mask:** `mask`=1010, `div`=0.
  - `a` alternates 1,3,1,3.
  - `en` high 1 of every 3 cycles.
  - `wrap` pulses on each 3→1.
- **Single bit:** `mask`=0100, `div`=1.
  - `a` stays 2 throughout.
  - `wrap` pulses on every step (every 4 cycles).
  - Checker confirms `a` never changes while `en`=1.
- **Mask cleared:** clear `mask` to 0000 during DWELL.
  - The current dwell completes.
  - Path is then BLANK_A → IDLE: `busy` falls, `a` is held, `en` stays 0.
  - A subsequent `start` with `mask`=0 leaves `busy`=0.
- **Stop/start priority:** `stop` and `start` high together during DWELL → IDLE after one edge (`en`=0, `busy`=0). Then `start` alone → `busy`=1, and `en` rises 2 edges later.
